cpu_mon: RTL and testbench

Parametrised CPU execution/access monitor for the tk1 SoC, sitting beside the tk1 control core on the same memory-mapped bus. Generalises the single fixed monitor window into NUM_REGIONS independently lockable address windows, each with separate instruction-fetch and data-access checks. Adds a sticky violation record with the faulting address, and a trap-indication LED blinker. Drives `force_trap` combinationally to the CPU.

---
 rtl/cpu_mon_pkg.sv | 25 ++
 rtl/cpu_mon_region.sv | 63 ++++++
 rtl/cpu_mon.sv | 166 ++++++++++++++++
 tb/tb_cpu_mon.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mon_pkg.sv
// cpu_mon shared definitions: register map, CTRL and STATUS bit positions.
package cpu_mon_pkg;

    localparam logic [7:0] ADDR_STATUS      = 8'h00;
    localparam logic [7:0] ADDR_VIOL_ADDR   = 8'h01;
    localparam logic [7:0] ADDR_INFO        = 8'h02;
    localparam logic [7:0] ADDR_REGION_BASE = 8'h10;
    localparam int         REGION_STRIDE    = 4;
    localparam int         MAX_REGIONS      = 8;

    localparam logic [1:0] SUB_CTRL  = 2'd0;
    localparam logic [1:0] SUB_FIRST = 2'd1;
    localparam logic [1:0] SUB_LAST  = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_LOCK = 1;
    localparam int CTRL_X    = 2;
    localparam int CTRL_D    = 3;

    localparam int ST_VIOL   = 0;
    localparam int ST_FW     = 1;
    localparam int ST_IDX_LO = 4;
    localparam int ST_RVALID = 7;

endpackage

// File: rtl/cpu_mon_region.sv
// One lockable monitor window: CTRL/FIRST/LAST registers and match logic.
module cpu_mon_region
    import cpu_mon_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [1:0]  sub,
    input  logic [31:0] wr_data,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    output logic        match,
    output logic [31:0] rd_data
);

    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] first_q, first_d;
    logic [31:0] last_q, last_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        first_d = first_q;
        last_d  = last_q;
        // A set lock freezes the whole window until reset.
        if (wr_en && !ctrl_q[CTRL_LOCK]) begin
            case (sub)
                SUB_CTRL:  ctrl_d  = wr_data[3:0];
                SUB_FIRST: first_d = wr_data;
                SUB_LAST:  last_d  = wr_data;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        match = cpu_valid && ctrl_q[CTRL_EN]
             && (cpu_addr >= first_q) && (cpu_addr <= last_q)
             && ((cpu_instr && ctrl_q[CTRL_X]) || (!cpu_instr && ctrl_q[CTRL_D]));
    end

    always_comb begin
        case (sub)
            SUB_CTRL:  rd_data = {28'b0, ctrl_q};
            SUB_FIRST: rd_data = first_q;
            SUB_LAST:  rd_data = last_q;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: rtl/cpu_mon.sv
// CPU execution/access monitor: fw-RAM fetch guard, region windows,
// sticky violation record and trap LED blinker.
module cpu_mon
    import cpu_mon_pkg::*;
#(
    parameter int          NUM_REGIONS  = 4,
    parameter int          BLINK_WIDTH  = 24,
    parameter logic [31:0] FW_RAM_FIRST = 32'hd0000000,
    parameter logic [31:0] FW_RAM_LAST  = 32'hd00007ff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fw_app_mode,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_trap,
    output logic        force_trap,
    output logic        violation,
    output logic [2:0]  trap_led,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    logic [7:0]             reg_off;
    logic                   reg_hit;
    logic [2:0]             reg_idx;
    logic [1:0]             reg_sub;
    logic [NUM_REGIONS-1:0] match;
    logic [31:0]            region_rd [NUM_REGIONS];

    always_comb begin
        reg_off = address - ADDR_REGION_BASE;
        reg_hit = reg_off < 8'(MAX_REGIONS * REGION_STRIDE);
        reg_idx = reg_off[4:2];
        reg_sub = reg_off[1:0];
    end

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        cpu_mon_region u_region (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en     (cs && we && reg_hit && (reg_idx == 3'(i))),
            .sub       (reg_sub),
            .wr_data   (write_data),
            .cpu_valid (cpu_valid),
            .cpu_instr (cpu_instr),
            .cpu_addr  (cpu_addr),
            .match     (match[i]),
            .rd_data   (region_rd[i])
        );
    end

    logic       fw_hit;
    logic [2:0] hit_idx;

    always_comb begin
        fw_hit = cpu_valid && cpu_instr
              && (cpu_addr >= FW_RAM_FIRST) && (cpu_addr <= FW_RAM_LAST);
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = 3'(i);
        end
        force_trap = fw_hit || (|match);
    end

    logic        viol_q, viol_d;
    logic        fw_q, fw_d;
    logic [2:0]  idx_q, idx_d;
    logic        rv_q, rv_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic        clr;
    logic        cap;

    always_comb begin
        clr = cs && we && (address == ADDR_STATUS)
           && write_data[0] && !fw_app_mode;
        // A match in the clearing cycle re-arms the record immediately.
        cap = force_trap && (!viol_q || clr);
        viol_d  = viol_q;
        fw_d    = fw_q;
        idx_d   = idx_q;
        rv_d    = rv_q;
        vaddr_d = vaddr_q;
        if (cap) begin
            viol_d  = 1'b1;
            fw_d    = fw_hit;
            idx_d   = hit_idx;
            rv_d    = |match;
            vaddr_d = cpu_addr;
        end else if (clr) begin
            viol_d  = 1'b0;
            fw_d    = 1'b0;
            idx_d   = '0;
            rv_d    = 1'b0;
            vaddr_d = '0;
        end
    end

    logic [BLINK_WIDTH-1:0] cnt_q, cnt_d;
    logic                   led_q, led_d;

    always_comb begin
        cnt_d = cnt_q + BLINK_WIDTH'(1);
        led_d = (cnt_q == '0) ? !led_q : led_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            viol_q  <= 1'b0;
            fw_q    <= 1'b0;
            idx_q   <= '0;
            rv_q    <= 1'b0;
            vaddr_q <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            viol_q  <= viol_d;
            fw_q    <= fw_d;
            idx_q   <= idx_d;
            rv_q    <= rv_d;
            vaddr_q <= vaddr_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    logic [31:0] status;

    always_comb begin
        status                 = '0;
        status[ST_VIOL]        = viol_q;
        status[ST_FW]          = fw_q;
        status[ST_IDX_LO+:3]   = idx_q;
        status[ST_RVALID]      = rv_q;
    end

    always_comb begin
        read_data = '0;
        if (cs && !we) begin
            if (address == ADDR_STATUS) begin
                read_data = status;
            end else if (address == ADDR_VIOL_ADDR) begin
                read_data = vaddr_q;
            end else if (address == ADDR_INFO) begin
                read_data = {28'b0, 4'(NUM_REGIONS)};
            end else if (reg_hit) begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (reg_idx == 3'(i)) read_data = region_rd[i];
                end
            end
        end
    end

    logic unused_trap;

    assign unused_trap = cpu_trap;
    assign ready       = cs;
    assign violation   = viol_q;
    assign trap_led    = {led_q, 2'b00};

endmodule

// File: tb/tb_cpu_mon.sv
// Directed self-checking bench for cpu_mon (4 regions, 4-bit blinker).
module tb_cpu_mon;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fw_app_mode;
    logic        cpu_valid;
    logic        cpu_instr;
    logic [31:0] cpu_addr;
    logic        cpu_trap;
    logic        force_trap;
    logic        violation;
    logic [2:0]  trap_led;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    int checks = 0;
    int errors = 0;

    cpu_mon #(
        .NUM_REGIONS (4),
        .BLINK_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fw_app_mode (fw_app_mode),
        .cpu_valid   (cpu_valid),
        .cpu_instr   (cpu_instr),
        .cpu_addr    (cpu_addr),
        .cpu_trap    (cpu_trap),
        .force_trap  (force_trap),
        .violation   (violation),
        .trap_led    (trap_led),
        .cs          (cs),
        .we          (we),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        @(posedge clk);
        #1 cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; address = a;
        #1 d = read_data;
        @(posedge clk);
        #1 cs = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic cpu_req(input string tag, input logic instr,
                           input logic [31:0] a, input logic exp_trap);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = a;
        #1 chk(tag, 32'(force_trap), 32'(exp_trap));
        @(posedge clk);
        #1 cpu_valid = 1'b0;
    endtask

    initial begin
        logic led_m;
        reset_n = 1'b0; fw_app_mode = 1'b0; cpu_valid = 1'b0;
        cpu_instr = 1'b0; cpu_addr = '0; cpu_trap = 1'b0;
        cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_viol", 32'(violation), 32'd0);
        chk("rst_led", 32'(trap_led), 32'd0);
        chk("rst_trap", 32'(force_trap), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        reset_n = 1'b1;

        led_m = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if ((k - 1) % 16 == 0) led_m = ~led_m;
            chk($sformatf("blink_c%0d", k), 32'(trap_led), 32'({led_m, 2'b00}));
        end

        rd_chk("rst_status", 8'h00, 32'h0);
        rd_chk("rst_vaddr", 8'h01, 32'h0);
        rd_chk("info", 8'h02, 32'h4);
        rd_chk("rst_ctrl0", 8'h10, 32'h0);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; address = 8'h02;
        #1 chk("ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1 cs = 1'b0;

        cpu_req("fw_fetch", 1'b1, 32'hd0000010, 1'b1);
        chk("fw_viol", 32'(violation), 32'd1);
        rd_chk("fw_status", 8'h00, 32'h3);
        rd_chk("fw_vaddr", 8'h01, 32'hd0000010);
        cpu_req("fw_data", 1'b0, 32'hd0000010, 1'b0);
        bus_wr(8'h00, 32'h1);
        chk("clr0", 32'(violation), 32'd0);

        bus_wr(8'h15, 32'h4000_0000);
        bus_wr(8'h16, 32'h4000_0fff);
        bus_wr(8'h14, 32'h5);
        rd_chk("r1_first", 8'h15, 32'h4000_0000);
        cpu_req("r1_last", 1'b1, 32'h4000_0fff, 1'b1);
        rd_chk("r1_status", 8'h00, 32'h91);
        cpu_req("r1_first_f", 1'b1, 32'h4000_0000, 1'b1);
        bus_wr(8'h00, 32'h1);
        cpu_req("r1_above", 1'b1, 32'h4000_1000, 1'b0);
        cpu_req("r1_data", 1'b0, 32'h4000_0000, 1'b0);
        chk("r1_noviol", 32'(violation), 32'd0);

        bus_wr(8'h11, 32'h10);
        bus_wr(8'h12, 32'h2ff);
        bus_wr(8'h10, 32'h9);
        bus_wr(8'h19, 32'h100);
        bus_wr(8'h1a, 32'h100);
        bus_wr(8'h18, 32'h9);
        cpu_req("r02_trap", 1'b0, 32'h100, 1'b1);
        rd_chk("r02_status", 8'h00, 32'h81);
        cpu_req("r0_2nd", 1'b0, 32'h200, 1'b1);
        rd_chk("sticky_vaddr", 8'h01, 32'h100);

        fw_app_mode = 1'b1;
        bus_wr(8'h00, 32'h1);
        chk("clr_app", 32'(violation), 32'd1);
        fw_app_mode = 1'b0;
        bus_wr(8'h00, 32'h1);
        chk("clr_fw", 32'(violation), 32'd0);
        rd_chk("clr_status", 8'h00, 32'h0);
        rd_chk("clr_vaddr", 8'h01, 32'h0);

        bus_wr(8'h1d, 32'h5000);
        bus_wr(8'h1e, 32'h5000);
        bus_wr(8'h1c, 32'hd);
        cpu_req("r3_trap", 1'b0, 32'h5000, 1'b1);
        rd_chk("r3_status", 8'h00, 32'hb1);
        bus_wr(8'h00, 32'h1);
        bus_wr(8'h1d, 32'h6000);
        bus_wr(8'h1e, 32'h5fff);
        cpu_req("inv_hi", 1'b0, 32'h6000, 1'b0);
        cpu_req("inv_lo", 1'b0, 32'h5fff, 1'b0);

        cpu_req("pre_coin", 1'b0, 32'h200, 1'b1);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; address = 8'h00; write_data = 32'h1;
        cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h250;
        @(posedge clk);
        #1 cs = 1'b0; we = 1'b0; cpu_valid = 1'b0;
        chk("coin_viol", 32'(violation), 32'd1);
        rd_chk("coin_vaddr", 8'h01, 32'h250);

        rd_chk("unimpl_03", 8'h03, 32'h0);
        rd_chk("unimpl_13", 8'h13, 32'h0);
        bus_wr(8'h21, 32'h1234);
        rd_chk("region4", 8'h21, 32'h0);

        bus_wr(8'h10, 32'h3);
        bus_wr(8'h11, 32'hffff_ffff);
        rd_chk("lock_first", 8'h11, 32'h10);
        rd_chk("lock_ctrl", 8'h10, 32'h3);

        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst_viol", 32'(violation), 32'd0);
        rd_chk("mid_rst_ctrl", 8'h10, 32'h0);
        rd_chk("mid_rst_status", 8'h00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
